// File: rtl/bp_be_dcache_port_arb.sv
// ---------------------------------------------------------------------------
// bp_be_dcache_port_arb
//
// Shares the single D$ request port between the pipeline and the page-table
// walker (PTW). The PTW has priority: when it asks for the port, the
// pipeline is blocked, pipeline requests already in flight are allowed to
// drain, and the PTW then owns the port until it signals the walk is done.
// A two-entry shadow pipeline (mem1 -> mem2) follows every issued request so
// the D$ early/hit response, which comes back two cycles after issue, can be
// routed to whoever issued it.
//
// Optional feature: define BP_BE_DCACHE_ARB_STALL_CNT_EN to build a saturating
// counter of cycles in which the pipeline wanted the port but was blocked.
// Without the macro stall_cnt_o is tied to zero and no counter is built.
//
// Ports
//   clk_i, reset_i     clock; synchronous active-high reset
//   flush_i            squash pipeline-owned requests (issue and in-flight)
//   pipe_v_i/pkt_i     pipeline request, pipe_ready_o grants it
//   ptw_v_i/pkt_i      PTW request, ptw_ready_o grants it
//   ptw_done_i         PTW walk finished, releases the lock
//   dcache_v_o/pkt_o   shared D$ request, dcache_ready_i is D$ back-pressure
//   dcache_early_v_i   D$ hit/early data, valid two cycles after issue
//   pipe_early_v_o     routed hit for a pipeline request
//   ptw_early_v_o      routed hit for a PTW request
//   pipe_miss_o        pipeline request came back without early data
//   stall_cnt_o        pipeline stall cycle count (0 if feature disabled)
//   state_o            current arbiter state, for debug and checkers
//
// Handshake: a transfer happens in a cycle where valid and ready are both 1.
// Ready is computed without looking at the requester's own valid, so a
// requester may hold valid and wait; the D$ side sees dcache_v_o only in the
// cycle the transfer actually happens, with the packet on dcache_pkt_o in
// that same cycle (no buffering).
// ---------------------------------------------------------------------------
module bp_be_dcache_port_arb #(
    parameter int pkt_width_p       = 64,
    parameter int stall_cnt_width_p = 16
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         flush_i,

    input  logic                         pipe_v_i,
    input  logic [pkt_width_p-1:0]       pipe_pkt_i,
    output logic                         pipe_ready_o,

    input  logic                         ptw_v_i,
    input  logic [pkt_width_p-1:0]       ptw_pkt_i,
    output logic                         ptw_ready_o,
    input  logic                         ptw_done_i,

    output logic                         dcache_v_o,
    output logic [pkt_width_p-1:0]       dcache_pkt_o,
    input  logic                         dcache_ready_i,

    input  logic                         dcache_early_v_i,
    output logic                         pipe_early_v_o,
    output logic                         ptw_early_v_o,
    output logic                         pipe_miss_o,

    output logic [stall_cnt_width_p-1:0] stall_cnt_o,
    output logic [1:0]                   state_o
);

    typedef enum logic [1:0] {
        e_idle     = 2'd0,
        e_drain    = 2'd1,
        e_ptw_lock = 2'd2
    } state_e;

    // One in-flight tracking slot: is a request there, and who owns it.
    typedef struct packed {
        logic v;
        logic is_ptw;
    } mem_entry_s;

    state_e     state_q, state_n;
    mem_entry_s mem1_q, mem2_q;
    mem_entry_s mem1_f, mem2_f;
    mem_entry_s mem1_n;
    logic       pipe_inflight;
    logic       pipe_grant;
    logic       ptw_grant;

    // -----------------------------------------------------------------------
    // Flush view of the in-flight slots. A flush kills pipeline-owned entries
    // combinationally so their responses are suppressed in the flush cycle
    // itself, and the killed valid bit is what shifts on. PTW entries pass.
    // -----------------------------------------------------------------------
    always_comb begin
        mem1_f   = mem1_q;
        mem2_f   = mem2_q;
        mem1_f.v = mem1_q.v & ~(flush_i & ~mem1_q.is_ptw);
        mem2_f.v = mem2_q.v & ~(flush_i & ~mem2_q.is_ptw);
    end

    // Pipeline entries still waiting for their response; the PTW may only
    // take the port once these are gone so responses are never misrouted.
    assign pipe_inflight = (mem1_f.v & ~mem1_f.is_ptw)
                         | (mem2_f.v & ~mem2_f.is_ptw);

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= e_idle;
        end else begin
            state_q <= state_n;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_n = state_q;
        unique case (state_q)
            e_idle: begin
                if (ptw_v_i) begin
                    state_n = pipe_inflight ? e_drain : e_ptw_lock;
                end
            end
            e_drain: begin
                // A PTW that gives up while we drain returns control to the
                // pipeline rather than locking the port for nobody.
                if (!ptw_v_i) begin
                    state_n = e_idle;
                end else if (!pipe_inflight) begin
                    state_n = e_ptw_lock;
                end
            end
            e_ptw_lock: begin
                // A new ptw_v_i in the same cycle as done is not carried over;
                // it re-arbitrates from IDLE like any other walk.
                if (ptw_done_i) begin
                    state_n = e_idle;
                end
            end
            default: begin
                state_n = e_idle;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs
    // All ready/valid outputs are held low while reset_i is asserted, even
    // before the reset edge has cleared the state and tracking registers.
    // -----------------------------------------------------------------------
    always_comb begin
        pipe_ready_o   = 1'b0;
        ptw_ready_o    = 1'b0;
        pipe_grant     = 1'b0;
        ptw_grant      = 1'b0;
        dcache_v_o     = 1'b0;
        dcache_pkt_o   = '0;
        pipe_early_v_o = 1'b0;
        ptw_early_v_o  = 1'b0;
        pipe_miss_o    = 1'b0;

        if (!reset_i) begin
            // A PTW request in IDLE blocks the pipeline in that same cycle
            // without issuing itself, so a simultaneous pair grants nobody.
            pipe_ready_o = (state_q == e_idle) & ~ptw_v_i & ~flush_i
                         & dcache_ready_i;
            ptw_ready_o  = (state_q == e_ptw_lock) & dcache_ready_i;

            pipe_grant   = pipe_v_i & pipe_ready_o;
            ptw_grant    = ptw_v_i & ptw_ready_o;
            dcache_v_o   = pipe_grant | ptw_grant;

            // Grants are mutually exclusive because they depend on disjoint
            // states; the idle value of the packet bus is zero.
            if (ptw_grant) begin
                dcache_pkt_o = ptw_pkt_i;
            end else if (pipe_grant) begin
                dcache_pkt_o = pipe_pkt_i;
            end

            pipe_early_v_o = mem2_f.v & ~mem2_f.is_ptw &  dcache_early_v_i;
            ptw_early_v_o  = mem2_f.v &  mem2_f.is_ptw &  dcache_early_v_i;
            pipe_miss_o    = mem2_f.v & ~mem2_f.is_ptw & ~dcache_early_v_i;
        end
    end

    assign state_o = state_q;

    // -----------------------------------------------------------------------
    // In-flight tracking: a two-stage shift that advances every cycle,
    // whether or not anything was issued, matching the fixed D$ latency.
    // -----------------------------------------------------------------------
    always_comb begin
        mem1_n        = '0;
        mem1_n.v      = dcache_v_o;
        mem1_n.is_ptw = ptw_grant;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            mem1_q <= '0;
            mem2_q <= '0;
        end else begin
            mem1_q <= mem1_n;
            mem2_q <= mem1_f;
        end
    end

    // -----------------------------------------------------------------------
    // Optional pipeline stall counter. A flushed cycle is not a stall: the
    // request is being squashed, not waiting.
    // -----------------------------------------------------------------------
`ifdef BP_BE_DCACHE_ARB_STALL_CNT_EN
    logic [stall_cnt_width_p-1:0] stall_cnt_q;
    logic                         stall_cycle;

    assign stall_cycle = pipe_v_i & ~pipe_ready_o & ~flush_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stall_cnt_q <= '0;
        end else if (stall_cycle && !(&stall_cnt_q)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_bp_be_dcache_port_arb.sv
// ---------------------------------------------------------------------------
// Testbench for bp_be_dcache_port_arb.
// Each record of the vector table is one clock cycle: the inputs to drive and
// the outputs required in that cycle (state_o is the state the cycle runs
// in). Packets are random per cycle; whenever a record says a request is
// issued, the packet that should win is pushed onto exp_q and popped when
// the DUT actually raises dcache_v_o. The stall count is modelled alongside.
// ---------------------------------------------------------------------------
module tb_bp_be_dcache_port_arb;

    localparam int PW = 64;
`ifdef BP_BE_DCACHE_ARB_STALL_CNT_EN
    localparam int SW = 4;
`else
    localparam int SW = 16;
`endif

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_LOCK  = 2'd2;

    logic          clk;
    logic          reset;
    logic          flush;
    logic          pipe_v;
    logic [PW-1:0] pipe_pkt;
    logic          pipe_ready;
    logic          ptw_v;
    logic [PW-1:0] ptw_pkt;
    logic          ptw_ready;
    logic          ptw_done;
    logic          dcache_v;
    logic [PW-1:0] dcache_pkt;
    logic          dcache_ready;
    logic          dcache_early_v;
    logic          pipe_early_v;
    logic          ptw_early_v;
    logic          pipe_miss;
    logic [SW-1:0] stall_cnt;
    logic [1:0]    state;

    bp_be_dcache_port_arb #(
        .pkt_width_p      (PW),
        .stall_cnt_width_p(SW)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset),
        .flush_i         (flush),
        .pipe_v_i        (pipe_v),
        .pipe_pkt_i      (pipe_pkt),
        .pipe_ready_o    (pipe_ready),
        .ptw_v_i         (ptw_v),
        .ptw_pkt_i       (ptw_pkt),
        .ptw_ready_o     (ptw_ready),
        .ptw_done_i      (ptw_done),
        .dcache_v_o      (dcache_v),
        .dcache_pkt_o    (dcache_pkt),
        .dcache_ready_i  (dcache_ready),
        .dcache_early_v_i(dcache_early_v),
        .pipe_early_v_o  (pipe_early_v),
        .ptw_early_v_o   (ptw_early_v),
        .pipe_miss_o     (pipe_miss),
        .stall_cnt_o     (stall_cnt),
        .state_o         (state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- vectors and scoreboard ----------------
    typedef struct {
        logic       rst, pv, tv, done, fl, rdy, early;
        logic       prdy, trdy, dv, pe, te, miss;
        logic [1:0] st;
    } vec_t;

    vec_t          tbl[$];
    logic [PW-1:0] exp_q[$];
    logic [SW-1:0] exp_stall;
    int            n_cmp;
    int            n_bad;

    // in  = {rst, pipe_v, ptw_v, ptw_done, flush, dcache_ready, early_v}
    // out = {pipe_ready, ptw_ready, dcache_v, pipe_early, ptw_early, miss}
    function automatic vec_t mk(input logic [6:0] in, input logic [5:0] out,
                                input logic [1:0] st);
        vec_t v;
        {v.rst, v.pv, v.tv, v.done, v.fl, v.rdy, v.early} = in;
        {v.prdy, v.trdy, v.dv, v.pe, v.te, v.miss} = out;
        v.st = st;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle on the falling edge, check just after, then let the
    // rising edge commit it.
    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        reset          = v.rst;
        pipe_v         = v.pv;
        ptw_v          = v.tv;
        ptw_done       = v.done;
        flush          = v.fl;
        dcache_ready   = v.rdy;
        dcache_early_v = v.early;
        pipe_pkt       = {$urandom, $urandom};
        ptw_pkt        = {$urandom, $urandom};
        if (v.dv) exp_q.push_back(v.trdy ? ptw_pkt : pipe_pkt);
        #1;
        chk({tag, ".pipe_ready"}, 64'(pipe_ready), 64'(v.prdy));
        chk({tag, ".ptw_ready"},  64'(ptw_ready),  64'(v.trdy));
        chk({tag, ".dcache_v"},   64'(dcache_v),   64'(v.dv));
        chk({tag, ".pipe_early"}, 64'(pipe_early_v), 64'(v.pe));
        chk({tag, ".ptw_early"},  64'(ptw_early_v),  64'(v.te));
        chk({tag, ".pipe_miss"},  64'(pipe_miss),  64'(v.miss));
        chk({tag, ".state"},      64'(state),      64'(v.st));
        chk({tag, ".stall_cnt"},  64'(stall_cnt),  64'(exp_stall));
        if (dcache_v) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s.pkt: unexpected issue %0h, expected none",
                         tag, dcache_pkt);
            end else begin
                chk({tag, ".pkt"}, dcache_pkt, exp_q.pop_front());
            end
        end
        if (v.rst) begin
            exp_stall = '0;
        end
`ifdef BP_BE_DCACHE_ARB_STALL_CNT_EN
        else if (v.pv && !v.prdy && !v.fl && exp_stall != '1) begin
            exp_stall = exp_stall + 1'b1;
        end
`endif
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        exp_stall = '0;
        reset = 1'b1;
        flush = 1'b0;
        pipe_v = 1'b0;
        ptw_v = 1'b0;
        ptw_done = 1'b0;
        dcache_ready = 1'b0;
        dcache_early_v = 1'b0;
        pipe_pkt = '0;
        ptw_pkt = '0;
        repeat (3) @(posedge clk);

        //                rpTdfre     PTDpTm
        // reset state, outputs held low during reset
        tbl.push_back(mk(7'b1110011, 6'b000000, S_IDLE));
        // pipe only: 3 issues, hits two cycles later
        tbl.push_back(mk(7'b0100011, 6'b101000, S_IDLE));
        tbl.push_back(mk(7'b0100011, 6'b101000, S_IDLE));
        tbl.push_back(mk(7'b0100011, 6'b101100, S_IDLE));
        tbl.push_back(mk(7'b0000011, 6'b100100, S_IDLE));
        tbl.push_back(mk(7'b0000011, 6'b100100, S_IDLE));
        tbl.push_back(mk(7'b0000011, 6'b100000, S_IDLE));
        // miss lasts exactly one cycle
        tbl.push_back(mk(7'b0100010, 6'b101000, S_IDLE));
        tbl.push_back(mk(7'b0000010, 6'b100000, S_IDLE));
        tbl.push_back(mk(7'b0000010, 6'b100001, S_IDLE));
        tbl.push_back(mk(7'b0000010, 6'b100000, S_IDLE));
        // PTW arrives with two pipe entries in flight
        tbl.push_back(mk(7'b0100011, 6'b101000, S_IDLE));
        tbl.push_back(mk(7'b0100011, 6'b101000, S_IDLE));
        tbl.push_back(mk(7'b0110011, 6'b000100, S_IDLE));
        tbl.push_back(mk(7'b0110011, 6'b000100, S_DRAIN));
        tbl.push_back(mk(7'b0110011, 6'b000000, S_DRAIN));
        tbl.push_back(mk(7'b0110011, 6'b011000, S_LOCK));
        tbl.push_back(mk(7'b0100011, 6'b010000, S_LOCK));
        tbl.push_back(mk(7'b0100011, 6'b010010, S_LOCK));
        tbl.push_back(mk(7'b0101011, 6'b010000, S_LOCK));
        tbl.push_back(mk(7'b0100011, 6'b101000, S_IDLE));
        // done with ptw_v in lock, then flush with a PTW entry in flight
        tbl.push_back(mk(7'b0010011, 6'b000000, S_IDLE));
        tbl.push_back(mk(7'b0010011, 6'b000100, S_DRAIN));
        tbl.push_back(mk(7'b0010011, 6'b000000, S_DRAIN));
        tbl.push_back(mk(7'b0011011, 6'b011000, S_LOCK));
        tbl.push_back(mk(7'b0100011, 6'b101000, S_IDLE));
        tbl.push_back(mk(7'b0000111, 6'b000010, S_IDLE));
        tbl.push_back(mk(7'b0100110, 6'b000000, S_IDLE));
        // D$ back-pressure
        tbl.push_back(mk(7'b0100001, 6'b000000, S_IDLE));
        tbl.push_back(mk(7'b0000011, 6'b100000, S_IDLE));
        // PTW with nothing in flight locks directly; PTW miss is not routed
        tbl.push_back(mk(7'b0010011, 6'b000000, S_IDLE));
        tbl.push_back(mk(7'b0010001, 6'b000000, S_LOCK));
        tbl.push_back(mk(7'b0010011, 6'b011000, S_LOCK));
        tbl.push_back(mk(7'b0000011, 6'b010000, S_LOCK));
        tbl.push_back(mk(7'b0000010, 6'b010000, S_LOCK));
        tbl.push_back(mk(7'b0001011, 6'b010000, S_LOCK));
        // PTW drops during drain; done ignored outside lock
        tbl.push_back(mk(7'b0100011, 6'b101000, S_IDLE));
        tbl.push_back(mk(7'b0011011, 6'b000000, S_IDLE));
        tbl.push_back(mk(7'b0000011, 6'b000100, S_DRAIN));
        tbl.push_back(mk(7'b0000011, 6'b100000, S_IDLE));
        // reset in lock with entries in flight
        tbl.push_back(mk(7'b0010011, 6'b000000, S_IDLE));
        tbl.push_back(mk(7'b0010011, 6'b011000, S_LOCK));
        tbl.push_back(mk(7'b0010011, 6'b011000, S_LOCK));
        tbl.push_back(mk(7'b1110011, 6'b000000, S_LOCK));
        tbl.push_back(mk(7'b0000011, 6'b100000, S_IDLE));
        tbl.push_back(mk(7'b0000011, 6'b100000, S_IDLE));

        foreach (tbl[i]) apply(tbl[i], $sformatf("v%0d", i));

        // flush while the pipe entry sits in mem2: hit suppressed that cycle
        apply(mk(7'b0100011, 6'b101000, S_IDLE), "fl2_issue");
        apply(mk(7'b0000011, 6'b100000, S_IDLE), "fl2_wait");
        apply(mk(7'b0000111, 6'b000000, S_IDLE), "fl2_flush");
        apply(mk(7'b0000010, 6'b100000, S_IDLE), "fl2_after");

        // pipeline blocked for 20 cycles by D$ back-pressure
        for (int i = 0; i < 20; i++) begin
            apply(mk(7'b0100000, 6'b000000, S_IDLE), $sformatf("stall%0d", i));
        end
        @(negedge clk);
        pipe_v = 1'b0;
        dcache_ready = 1'b1;
        #1;
`ifdef BP_BE_DCACHE_ARB_STALL_CNT_EN
        chk("stall_saturated", 64'(stall_cnt), 64'd15);
`else
        chk("stall_disabled", 64'(stall_cnt), 64'd0);
`endif
        chk("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bp_be_dcache_port_arb.md
BP_BE_DCACHE_PORT_ARB -- requirements
Module: bp_be_dcache_port_arb

Interface
- REQ-001 SHALL have parameter pkt_width_p, default 64, width of a D$ request packet.
- REQ-002 SHALL have parameter stall_cnt_width_p, default 16, width of the stall counter.
- REQ-003 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
- REQ-004 SHALL have port reset_i, input, 1, synchronous active-high reset.
- REQ-005 SHALL have port flush_i, input, 1, squash pipeline-owned requests.
- REQ-006 SHALL have ports pipe_v_i (in, 1), pipe_pkt_i (in, pkt_width_p) and pipe_ready_o (out, 1), the pipeline requester.
- REQ-007 SHALL have ports ptw_v_i (in, 1), ptw_pkt_i (in, pkt_width_p), ptw_ready_o (out, 1) and ptw_done_i (in, 1, walk finished), the page-table-walker requester.
- REQ-008 SHALL have ports dcache_v_o (out, 1), dcache_pkt_o (out, pkt_width_p) and dcache_ready_i (in, 1), the shared D$ request port.
- REQ-009 SHALL have port dcache_early_v_i, input, 1, D$ hit/early-data valid 2 cycles after issue.
- REQ-010 SHALL have ports pipe_early_v_o, ptw_early_v_o and pipe_miss_o, each output, 1, the routed responses.
- REQ-011 SHALL have port stall_cnt_o, output, stall_cnt_width_p, pipeline stall cycle count.

Function
- REQ-012 SHALL implement states IDLE, DRAIN and PTW_LOCK.
- REQ-013 IDLE: on ptw_v_i=1, SHALL go to PTW_LOCK if no pipe-owned entry is in flight (after this cycle's flush), else to DRAIN.
- REQ-014 DRAIN: SHALL go to PTW_LOCK when no pipe-owned entries remain, and to IDLE if ptw_v_i drops first.
- REQ-015 PTW_LOCK: SHALL return to IDLE on ptw_done_i=1; ptw_done_i is ignored in all other states.
- REQ-016 SHALL drive pipe_ready_o = IDLE & ~ptw_v_i & ~flush_i & dcache_ready_i.
- REQ-017 SHALL drive ptw_ready_o = PTW_LOCK & dcache_ready_i.
- REQ-018 SHALL drive dcache_v_o = (pipe_v_i & pipe_ready_o) | (ptw_v_i & ptw_ready_o), with dcache_pkt_o muxed combinationally from the granted requester, zero-latency.
- REQ-019 SHALL track in-flight issues in a 2-stage shift register (mem1, mem2), each holding {valid, is_ptw}, shifting every cycle.
- REQ-020 SHALL drive pipe_early_v_o = mem2.v & ~mem2.is_ptw & dcache_early_v_i, ptw_early_v_o = mem2.v & mem2.is_ptw & dcache_early_v_i, and pipe_miss_o = mem2.v & ~mem2.is_ptw & ~dcache_early_v_i.
- REQ-021 flush_i SHALL clear the valid bit of pipe-owned mem1/mem2 entries in the same cycle, so the routed outputs are suppressed that cycle and thereafter; PTW entries are unaffected.
- REQ-022 Simultaneous ptw_v_i and pipe_v_i in IDLE SHALL grant neither that cycle, because the PTW has priority and IDLE never issues a PTW packet.
- REQ-023 Concurrent ptw_done_i and ptw_v_i in PTW_LOCK SHALL go to IDLE; the next walk re-arbitrates.

Reset
- REQ-024 reset_i SHALL force IDLE, clear mem1/mem2, and zero stall_cnt_o on the next edge, including mid-DRAIN or mid-PTW_LOCK.
- REQ-025 During reset all ready/valid outputs SHALL be 0.

Configuration
- REQ-026 With BP_BE_DCACHE_ARB_STALL_CNT_EN defined, stall_cnt_o SHALL increment, saturating at all-ones, each cycle pipe_v_i=1 & pipe_ready_o=0 & ~flush_i.
- REQ-027 Without BP_BE_DCACHE_ARB_STALL_CNT_EN, stall_cnt_o SHALL be constant 0 and no counter flops SHALL exist.

Verification
- REQ-028 Pipe only: pipe_v_i=1 for 3 cycles, dcache_ready_i=1, dcache_early_v_i=1 -> 3 issues; pipe_early_v_o=1 at cycles t+2..t+4; ptw_early_v_o=0.
- REQ-029 PTW during pipe traffic: ptw_v_i rises with 2 pipe entries in flight -> DRAIN for 2 cycles, PTW_LOCK, PTW packet issued, ptw_early_v_o 2 cycles later; ptw_done_i -> IDLE.
- REQ-030 Flush: pipe issue at t, flush_i at t+1 -> no pipe_early_v_o or pipe_miss_o at t+2; a PTW entry in flight still yields ptw_early_v_o.
- REQ-031 Miss: pipe issue with dcache_early_v_i=0 at t+2 -> pipe_miss_o=1 for exactly 1 cycle.
- REQ-032 Reset in PTW_LOCK with an entry in flight -> IDLE next cycle, no early/miss outputs, stall_cnt_o=0.
- REQ-033 Stall count (macro on, width 4): pipe_v_i held through 20 blocked cycles -> stall_cnt_o saturates at 15; macro off -> stall_cnt_o stays 0.
